uart_frame_loader: RTL and testbench

- Parametrised successor to the single-purpose UART ROM loader.
- Parses framed, checksummed commands from the UART receiver byte stream.
- Packs payload bytes into DATA_WIDTH words and issues them on a valid/ready write port, so one block can target program ROM, a DDR bridge or any other memory.
- Controls the system soft reset explicitly and returns an ACK/NAK byte per frame for the UART transmitter.

---
 rtl/uart_frame_loader_if.sv | 43 ++++
 rtl/uart_frame_loader.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_if.sv
// Byte-stream, word-write and response-byte signals of the frame loader.
// master = loader side, slave = UART/memory side.
interface uart_frame_loader_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]              rx_data;
  logic                    rx_data_ready;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_be;
  logic                    write_req;
  logic                    write_ready;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (
    input  rx_data,
    input  rx_data_ready,
    output write_addr,
    output write_data,
    output write_be,
    output write_req,
    input  write_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output rx_data,
    output rx_data_ready,
    input  write_addr,
    input  write_data,
    input  write_be,
    input  write_req,
    output write_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Framed, checksummed UART command parser: packs payload into words,
// drives a valid/ready write port, soft reset and ACK/NAK replies.
module uart_frame_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  uart_frame_loader_if.master bus,
  output logic               system_soft_reset
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int ABW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_LEN     = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_FLUSH   = 3'd6;
  localparam logic [2:0] S_RESP    = 3'd7;

  localparam logic [7:0] MAGIC = 8'hA5;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  logic [2:0]            state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ABW-1:0]        acnt_q, acnt_d;
  logic                  lcnt_q, lcnt_d;
  logic [15:0]           rem_q, rem_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  ovf_q, ovf_d;
  logic                  ok_q, ok_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wbe_q, wbe_d;
  logic                  txv_q, txv_d;
  logic [7:0]            txd_q, txd_d;
  logic                  srst_q, srst_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  out_free;
  logic                  active;
  logic                  tmo_fire;
  logic                  strobe;
  logic                  last_lane;
  logic                  chk_ok;
  logic [DATA_WIDTH-1:0] asm_nx;
  logic [NB-1:0]         be_part;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    acnt_d  = acnt_q;
    lcnt_d  = lcnt_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    ok_d    = ok_q;
    req_d   = req_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wbe_d   = wbe_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    srst_d  = srst_q;
    tmo_d   = tmo_q;

    out_free  = !req_q || bus.write_ready;
    active    = (state_q != S_IDLE) && (state_q != S_RESP);
    tmo_fire  = active && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    strobe    = bus.rx_data_ready && !tmo_fire;
    last_lane = (lane_q == LW'(NB - 1));
    chk_ok    = (bus.rx_data == sum_q);

    asm_nx = asm_q;
    asm_nx[{lane_q, 3'b000} +: 8] = bus.rx_data;
    for (int i = 0; i < NB; i++) begin
      be_part[i] = (LW'(i) < lane_q);
    end

    if (req_q && bus.write_ready) req_d = 1'b0;
    if (txv_q && bus.tx_ready) txv_d = 1'b0;

    if (bus.rx_data_ready) tmo_d = '0;
    else if (active) tmo_d = tmo_q + TW'(1);

    if (tmo_fire) begin
      // partial word is dropped; a pending write still completes
      tmo_d   = '0;
      lane_d  = '0;
      asm_d   = '0;
      state_d = S_RESP;
      txv_d   = 1'b1;
      txd_d   = NAK;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (strobe && bus.rx_data == MAGIC) begin
            state_d = S_CMD;
            sum_d   = '0;
            ovf_d   = 1'b0;
            lane_d  = '0;
            asm_d   = '0;
            acnt_d  = '0;
            lcnt_d  = 1'b0;
          end
        end
        S_CMD: begin
          if (strobe) begin
            cmd_d = bus.rx_data;
            sum_d = bus.rx_data;
            if (bus.rx_data == 8'h01) begin
              state_d = S_ADDR;
            end else if (bus.rx_data == 8'h02 || bus.rx_data == 8'h03) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_RESP;
              txv_d   = 1'b1;
              txd_d   = NAK;
            end
          end
        end
        S_ADDR: begin
          if (strobe) begin
            sum_d = sum_q + bus.rx_data;
            for (int i = 0; i < ADDR_WIDTH; i++) begin
              if (acnt_q == ABW'(i / 8)) addr_d[i] = bus.rx_data[i % 8];
            end
            acnt_d = acnt_q + ABW'(1);
            if (acnt_q == ABW'(ADDR_BYTES - 1)) state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (strobe) begin
            sum_d = sum_q + bus.rx_data;
            if (!lcnt_q) begin
              rem_d[7:0] = bus.rx_data;
              lcnt_d     = 1'b1;
            end else begin
              rem_d[15:8] = bus.rx_data;
              if ({bus.rx_data, rem_q[7:0]} == 16'd0) state_d = S_CHECK;
              else state_d = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (strobe) begin
            sum_d = sum_q + bus.rx_data;
            rem_d = rem_q - 16'd1;
            if (last_lane) begin
              lane_d = '0;
              asm_d  = '0;
              addr_d = addr_q + ADDR_WIDTH'(1);
              if (out_free) begin
                req_d   = 1'b1;
                waddr_d = addr_q;
                wdata_d = asm_nx;
                wbe_d   = '1;
              end else begin
                ovf_d = 1'b1;
              end
            end else begin
              lane_d = lane_q + LW'(1);
              asm_d  = asm_nx;
            end
            if (rem_q == 16'd1) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (strobe) begin
            if (cmd_q == 8'h01) begin
              ok_d    = chk_ok;
              state_d = S_FLUSH;
            end else begin
              if (chk_ok) srst_d = (cmd_q == 8'h02);
              state_d = S_RESP;
              txv_d   = 1'b1;
              txd_d   = chk_ok ? ACK : NAK;
            end
          end
        end
        S_FLUSH: begin
          if (lane_q != '0) begin
            if (out_free) begin
              req_d   = 1'b1;
              waddr_d = addr_q;
              wdata_d = asm_q;
              wbe_d   = be_part;
              lane_d  = '0;
              asm_d   = '0;
              addr_d  = addr_q + ADDR_WIDTH'(1);
            end
          end else if (!req_q) begin
            state_d = S_RESP;
            txv_d   = 1'b1;
            txd_d   = (ok_q && !ovf_q) ? ACK : NAK;
          end
        end
        S_RESP: begin
          if (txv_q && bus.tx_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      acnt_q  <= '0;
      lcnt_q  <= 1'b0;
      rem_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      ok_q    <= 1'b0;
      req_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wbe_q   <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      srst_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      acnt_q  <= acnt_d;
      lcnt_q  <= lcnt_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      ok_q    <= ok_d;
      req_q   <= req_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wbe_q   <= wbe_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      srst_q  <= srst_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.write_req      = req_q;
  assign bus.write_addr     = waddr_q;
  assign bus.write_data     = wdata_q;
  assign bus.write_be       = wbe_q;
  assign bus.tx_valid       = txv_q;
  assign bus.tx_data        = txd_q;
  assign system_soft_reset  = srst_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: write packing, wrap, checksum,
// soft reset commands, backpressure, timeout and mid-frame reset.
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); \
    end \
  end

module tb_uart_frame_loader;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic reset;
  logic soft_rst;
  int   total = 0;
  int   bad = 0;

  uart_frame_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uart_frame_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ADDR_BYTES(2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .system_soft_reset(soft_rst)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [NB-1:0] wb_q[$];
  logic [7:0]    tx_q[$];
  int            wrd = 0;
  int            trd = 0;
  logic [7:0]    fr[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.write_req && bus.write_ready) begin
        wa_q.push_back(bus.write_addr);
        wd_q.push_back(bus.write_data);
        wb_q.push_back(bus.write_be);
      end
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_data_ready = 1'b1;
    @(negedge clk);
    bus.rx_data_ready = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fr[i]);
  endtask

  function automatic logic [7:0] chk_of();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 1; i < fr.size(); i++) s = s + fr[i];
    return s;
  endfunction

  task automatic send_chk(input logic [7:0] x);
    send_byte(chk_of() ^ x);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 150 && tx_q.size() == trd; i++) @(negedge clk);
    if (tx_q.size() > trd) begin
      `CHK(tag, tx_q[trd], exp)
      trd++;
    end else begin
      total++;
      bad++;
      $error("FAIL %s obs=none exp=%0h", tag, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NB-1:0] be);
    if (wa_q.size() > wrd) begin
      `CHK({tag, "_a"}, wa_q[wrd], a)
      `CHK({tag, "_d"}, wd_q[wrd], d)
      `CHK({tag, "_be"}, wb_q[wrd], be)
      wrd++;
    end else begin
      total++;
      bad++;
      $error("FAIL %s obs=none exp=%0h", tag, a);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_data_ready = 1'b0;
    bus.write_ready = 1'b1;
    bus.tx_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    `CHK("rst_req", bus.write_req, 1'b0)
    `CHK("rst_txv", bus.tx_valid, 1'b0)
    `CHK("rst_srst", soft_rst, 1'b0)
    `CHK("rst_addr", bus.write_addr, 14'h0)
    `CHK("rst_data", bus.write_data, 32'h0)
    `CHK("rst_be", bus.write_be, 4'h0)

    // two full words
    fr = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h08, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_range(0, fr.size() - 1);
    send_chk(8'h00);
    expect_tx("wr_ack", 8'h06);
    expect_wr("wr0", 14'h0010, 32'h44332211, 4'hF);
    expect_wr("wr1", 14'h0011, 32'h88776655, 4'hF);
    `CHK("wr_cnt", wa_q.size() - wrd, 0)

    // partial word plus address wrap
    fr = '{8'hA5, 8'h01, 8'hFF, 8'h3F, 8'h05, 8'h00,
           8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send_range(0, fr.size() - 1);
    send_chk(8'h00);
    expect_tx("wrap_ack", 8'h06);
    expect_wr("wrap0", 14'h3FFF, 32'hDDCCBBAA, 4'hF);
    expect_wr("wrap1", 14'h0000, 32'h000000EE, 4'h1);

    // reset commands
    fr = '{8'hA5, 8'h02};
    send_range(0, 1);
    send_chk(8'h01);
    `CHK("rsta_bad_srst", soft_rst, 1'b0)
    expect_tx("rsta_bad_nak", 8'h15);
    bus.tx_ready = 1'b0;
    send_range(0, 1);
    send_chk(8'h00);
    `CHK("rsta_srst", soft_rst, 1'b1)
    `CHK("rsta_txv", bus.tx_valid, 1'b1)
    idle(3);
    `CHK("rsta_hold_v", bus.tx_valid, 1'b1)
    `CHK("rsta_hold_d", bus.tx_data, 8'h06)
    bus.tx_ready = 1'b1;
    expect_tx("rsta_ack", 8'h06);
    fr = '{8'hA5, 8'h03};
    send_range(0, 1);
    send_chk(8'h00);
    `CHK("rstr_srst", soft_rst, 1'b0)
    expect_tx("rstr_ack", 8'h06);

    // unknown command: NAK without CHK byte
    fr = '{8'hA5, 8'h07};
    send_range(0, 1);
    expect_tx("unk_nak", 8'h15);

    // LEN=0 write
    fr = '{8'hA5, 8'h01, 8'h70, 8'h00, 8'h00, 8'h00};
    send_range(0, fr.size() - 1);
    send_chk(8'h00);
    expect_tx("len0_ack", 8'h06);
    `CHK("len0_nwr", wa_q.size() - wrd, 0)

    // long backpressure: second word dropped
    bus.write_ready = 1'b0;
    fr = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h08, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_range(0, fr.size() - 1);
    send_chk(8'h00);
    `CHK("bp_req", bus.write_req, 1'b1)
    `CHK("bp_addr", bus.write_addr, 14'h0020)
    `CHK("bp_data", bus.write_data, 32'h04030201)
    `CHK("bp_notx", tx_q.size() - trd, 0)
    bus.write_ready = 1'b1;
    expect_tx("bp_nak", 8'h15);
    expect_wr("bp0", 14'h0020, 32'h04030201, 4'hF);
    `CHK("bp_cnt", wa_q.size() - wrd, 0)

    // short backpressure: everything written
    fr = '{8'hA5, 8'h01, 8'h30, 8'h00, 8'h08, 8'h00,
           8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    send_range(0, 8);
    bus.write_ready = 1'b0;
    send_byte(fr[9]);
    `CHK("sbp_req", bus.write_req, 1'b1)
    `CHK("sbp_addr", bus.write_addr, 14'h0030)
    idle(1);
    bus.write_ready = 1'b1;
    send_range(10, fr.size() - 1);
    send_chk(8'h00);
    expect_tx("sbp_ack", 8'h06);
    expect_wr("sbp0", 14'h0030, 32'hA3A2A1A0, 4'hF);
    expect_wr("sbp1", 14'h0031, 32'hA7A6A5A4, 4'hF);

    // timeout with partial word
    fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22};
    send_range(0, fr.size() - 1);
    idle(90);
    `CHK("tmo_early", tx_q.size() - trd, 0)
    expect_tx("tmo_nak", 8'h15);
    `CHK("tmo_nwr", wa_q.size() - wrd, 0)
    fr = '{8'hA5, 8'h01, 8'h40, 8'h00, 8'h04, 8'h00,
           8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_range(0, fr.size() - 1);
    send_chk(8'h00);
    expect_tx("tmo_next_ack", 8'h06);
    expect_wr("tmo_next", 14'h0040, 32'hEFBEADDE, 4'hF);

    // reset mid-payload with a pending write
    bus.write_ready = 1'b0;
    fr = '{8'hA5, 8'h01, 8'h50, 8'h00, 8'h08, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04};
    send_range(0, fr.size() - 1);
    `CHK("mid_req_pre", bus.write_req, 1'b1)
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    `CHK("mid_req", bus.write_req, 1'b0)
    `CHK("mid_txv", bus.tx_valid, 1'b0)
    bus.write_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h11);
    send_byte(8'h11);
    idle(5);
    `CHK("mid_notx", tx_q.size() - trd, 0)
    `CHK("mid_nwr", wa_q.size() - wrd, 0)
    fr = '{8'hA5, 8'h01, 8'h60, 8'h00, 8'h01, 8'h00, 8'h99};
    send_range(0, fr.size() - 1);
    send_chk(8'h00);
    expect_tx("mid_next_ack", 8'h06);
    expect_wr("mid_next", 14'h0060, 32'h00000099, 4'h1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
